// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM state encoding and datapath widths for the data memory responder
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 2;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage, synchronous write, asynchronous read on a single address port
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  // write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: wait-stated word memory responder (define DMEM_ALIGN_CHECK_EN to reject unaligned addresses)
module data_mem_resp
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mrd_en,
  input  logic [DATA_W-1:0] mra_d,
  input  logic              mwr_d,
  input  logic [DATA_W-1:0] mwa_d,
  input  logic [DATA_W-1:0] mwd_d,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mrd_d,
  output logic              mrd_valid,
  output logic              wr_done,
  output logic              err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, bad_q, bad_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, arr_rdata, in_addr;
  logic accept, enter_resp, in_bad, we;
  assign in_addr = mwr_d ? mwa_d : mra_d;
`ifdef DMEM_ALIGN_CHECK_EN
  assign in_bad = (|in_addr[DATA_W-1:IW+OFF_W]) | (|in_addr[OFF_W-1:0]);
`else
  logic unused_off;
  assign unused_off = ^in_addr[OFF_W-1:0];
  assign in_bad = |in_addr[DATA_W-1:IW+OFF_W];
`endif
  // next-state and capture; the _d copies of the request fields double as the
  // live transaction so a zero-wait access can write/read on its accept edge
  always_comb begin
    accept     = (state_q == IDLE) && (mwr_d || mrd_en);
    wr_d       = accept ? mwr_d : wr_q;
    bad_d      = accept ? in_bad : bad_q;
    idx_d      = accept ? in_addr[IW+OFF_W-1:OFF_W] : idx_q;
    wdata_d    = accept ? mwd_d : wdata_q;
    enter_resp = accept ? (4'(WAIT_CYCLES) == 4'd0) : (state_q == BUSY && cnt_q == 4'd1);
    state_d    = enter_resp ? RESP : accept ? BUSY : (state_q == BUSY) ? BUSY : IDLE;
    cnt_d      = accept ? 4'(WAIT_CYCLES) : (state_q == BUSY) ? cnt_q - 4'd1 : cnt_q;
    we         = enter_resp && wr_d && !bad_d;
    rdata_d    = (enter_resp && !wr_d) ? (bad_d ? '0 : arr_rdata) : rdata_q;
  end
  // state and captured request, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(IW)) u_arr (
    .clk  (clk),
    .we   (we),
    .addr (idx_d),
    .wdata(wdata_d),
    .rdata(arr_rdata)
  );
  assign mem_ready = state_q == IDLE;
  assign mrd_d     = rdata_q;
  assign mrd_valid = state_q == RESP && !wr_q;
  assign wr_done   = state_q == RESP && wr_q && !bad_q;
  assign err       = state_q == RESP && bad_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed checks of data_mem_resp at WAIT_CYCLES 0, 1 and 3
module tb_data_mem_resp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[3];
  logic rd[3], wr[3], rdy[3], vld[3], done[3], er[3];
  logic [31:0] ra[3], wa[3], wd[3], rdat[3];
  int checks = 0;
  int errors = 0;
  data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst_n[0]), .mrd_en(rd[0]), .mra_d(ra[0]),
    .mwr_d(wr[0]), .mwa_d(wa[0]), .mwd_d(wd[0]), .mem_ready(rdy[0]), .mrd_d(rdat[0]), .mrd_valid(vld[0]), .wr_done(done[0]), .err(er[0]));
  data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u1 (.clk(clk), .reset(rst_n[1]), .mrd_en(rd[1]), .mra_d(ra[1]),
    .mwr_d(wr[1]), .mwa_d(wa[1]), .mwd_d(wd[1]), .mem_ready(rdy[1]), .mrd_d(rdat[1]), .mrd_valid(vld[1]), .wr_done(done[1]), .err(er[1]));
  data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u2 (.clk(clk), .reset(rst_n[2]), .mrd_en(rd[2]), .mra_d(ra[2]),
    .mwr_d(wr[2]), .mwa_d(wa[2]), .mwd_d(wd[2]), .mem_ready(rdy[2]), .mrd_d(rdat[2]), .mrd_valid(vld[2]), .wr_done(done[2]), .err(er[2]));

  typedef struct packed {
    logic w, r;
    logic [31:0] a, d, exp_d;
    logic exp_v, exp_w, exp_e;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic txn(input int i, input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] got_d, output logic got_v, output logic got_w, output logic got_e, output int lat);
    @(negedge clk);
    wr[i] = w; rd[i] = r; ra[i] = a; wa[i] = a; wd[i] = d;
    @(posedge clk);
    #1;
    wr[i] = 1'b0; rd[i] = 1'b0;
    lat = -1; got_v = 1'b0; got_w = 1'b0; got_e = 1'b0; got_d = '0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (vld[i] || done[i] || er[i]) begin
        lat = c; got_d = rdat[i]; got_v = vld[i]; got_w = done[i]; got_e = er[i];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] gd;
    logic gv, gw, ge;
    int lat;
    logic [31:0] sa[3];
    logic [31:0] sd[3];
    logic seen;
    v[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b0};
    v[1]  = '{1'b0, 1'b1, 32'h10,       32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    v[2]  = '{1'b1, 1'b0, 32'h0,        32'h11111111, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    v[3]  = '{1'b1, 1'b0, 32'h400,      32'hAAAA5555, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    v[4]  = '{1'b0, 1'b1, 32'h0,        32'h0,        32'h11111111, 1'b1, 1'b0, 1'b0};
    v[5]  = '{1'b0, 1'b1, 32'h400,      32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
    v[6]  = '{1'b1, 1'b1, 32'h20,       32'h1234,     32'h0,        1'b0, 1'b1, 1'b0};
    v[7]  = '{1'b0, 1'b1, 32'h20,       32'h0,        32'h1234,     1'b1, 1'b0, 1'b0};
    v[8]  = '{1'b1, 1'b0, 32'h3FC,      32'hCAFEF00D, 32'h1234,     1'b0, 1'b1, 1'b0};
    v[9]  = '{1'b0, 1'b1, 32'h3FC,      32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    v[10] = '{1'b0, 1'b1, 32'h12,       32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
`else
    v[10] = '{1'b0, 1'b1, 32'h12,       32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
`endif
    v[11] = '{1'b0, 1'b1, 32'h80000010, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; ra[i] = '0; wa[i] = '0; wd[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready%0d", i), rdy[i], 1);
      chk($sformatf("reset_pulses%0d", i), {vld[i], done[i], er[i]}, 0);
      chk($sformatf("reset_rdata%0d", i), rdat[i], 0);
      rst_n[i] = 1'b1;
    end

    for (int k = 0; k < 12; k++) begin
      txn(1, v[k].w, v[k].r, v[k].a, v[k].d, gd, gv, gw, ge, lat);
      chk($sformatf("v%0d_latency", k), lat, 2);
      chk($sformatf("v%0d_rdata", k), gd, v[k].exp_d);
      chk($sformatf("v%0d_valid", k), gv, v[k].exp_v);
      chk($sformatf("v%0d_wr_done", k), gw, v[k].exp_w);
      chk($sformatf("v%0d_err", k), ge, v[k].exp_e);
    end

    sa[0] = 32'h0; sa[1] = 32'h4; sa[2] = 32'h8;
    sd[0] = 32'hA0A0A0A0; sd[1] = 32'hA1A1A1A1; sd[2] = 32'hA2A2A2A2;
    for (int k = 0; k < 3; k++) begin
      txn(0, 1'b1, 1'b0, sa[k], sd[k], gd, gv, gw, ge, lat);
      chk($sformatf("w0_store%0d_latency", k), lat, 1);
      chk($sformatf("w0_store%0d_done", k), gw, 1);
    end
    begin
      int j = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk($sformatf("w0_stream_ready%0d", c), rdy[0], (c % 2 == 0));
        chk($sformatf("w0_stream_valid%0d", c), vld[0], (c % 2 == 1));
        if (c % 2 == 1) chk($sformatf("w0_stream_data%0d", c), rdat[0], sd[c/2]);
        if (c % 2 == 0 && j < 3) begin
          rd[0] = 1'b1; ra[0] = sa[j]; j++;
        end else rd[0] = 1'b0;
      end
      rd[0] = 1'b0;
    end

    txn(2, 1'b1, 1'b0, 32'h30, 32'h55, gd, gv, gw, ge, lat);
    chk("w3_store_latency", lat, 4);
    chk("w3_store_done", gw, 1);
    @(negedge clk);
    wr[2] = 1'b1; wa[2] = 32'h30; wd[2] = 32'h99;
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    chk("w3_busy_ready", rdy[2], 0);
    @(posedge clk);
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("w3_async_reset_ready", rdy[2], 1);
    @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done[2] || vld[2] || er[2]) seen = 1'b1;
    end
    chk("w3_abandoned_no_pulse", seen, 0);
    chk("w3_ready_after_release", rdy[2], 1);
    txn(2, 1'b0, 1'b1, 32'h30, 32'h0, gd, gv, gw, ge, lat);
    chk("w3_load_latency", lat, 4);
    chk("w3_word_unchanged", gd, 32'h55);
    chk("w3_load_valid", gv, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words; power of two, 16..4096.
REQ-002 Parameter WAIT_CYCLES, default 1, wait states inserted per access; range 0..15.
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Port mrd_en  input  1  load request, sampled only when mem_ready=1.
REQ-006 Port mra_d  input  32  load byte address.
REQ-007 Port mwr_d  input  1  store request, sampled only when mem_ready=1.
REQ-008 Port mwa_d  input  32  store byte address.
REQ-009 Port mwd_d  input  32  store data.
REQ-010 Port mem_ready  output  1  responder idle and accepting a request this cycle.
REQ-011 Port mrd_d  output  32  load data, registered.
REQ-012 Port mrd_valid  output  1  one-cycle pulse, mrd_d carries the new load result.
REQ-013 Port wr_done  output  1  one-cycle pulse, store committed to the array.
REQ-014 Port err  output  1  one-cycle pulse, access rejected (see REQ-022, REQ-030).

Function
REQ-015 FSM states IDLE, BUSY, RESP; mem_ready=1 only in IDLE.
REQ-016 IDLE with mwr_d=1 or mrd_en=1 at an edge: request captured (type, address, data), go BUSY if WAIT_CYCLES>0, else RESP.
REQ-017 mwr_d and mrd_en both 1 at accept: store performed, load discarded, no mrd_valid for that transaction.
REQ-018 BUSY counts WAIT_CYCLES cycles on a 4-bit down-counter, then RESP; inputs ignored in BUSY/RESP.
REQ-019 RESP lasts exactly one cycle, then IDLE; back-to-back accept possible the cycle after RESP.
REQ-020 Latency: accept at edge N; mrd_valid or wr_done is high during cycle N+WAIT_CYCLES+1.
REQ-021 Word index = address[log2(DEPTH_WORDS)+1:2]; address bits [1:0] ignored.
REQ-022 Address bits above the index nonzero: store dropped, load returns 32'h0 with mrd_valid=1; err=1 in RESP.
REQ-023 Store written into the array at the edge entering RESP; a later load to the same word returns the new data.
REQ-024 mrd_d updates only in the RESP cycle of a load; it holds its value otherwise.
REQ-025 wr_done and mrd_valid are never high in the same cycle.

Reset
REQ-026 reset=0 forces, asynchronously: state IDLE, counter 0, mrd_d=0, mrd_valid=0, wr_done=0, err=0; mem_ready=1 after release.
REQ-027 Reset in BUSY or RESP abandons the transaction: no pulse, store not committed unless already written at the RESP edge.
REQ-028 Array contents are not cleared by reset; a load of a never-written word returns unspecified data.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN selects alignment checking.
REQ-030 Defined: an address with bits [1:0] not 00 is rejected like REQ-022 (store dropped, load returns 0, err=1).
REQ-031 Undefined: bits [1:0] ignored; err is raised only for out-of-range addresses.

Structure
REQ-032 Shared package mips_pkg holds the FSM state enum (IDLE/BUSY/RESP), data width 32 and the word-offset width 2.
REQ-033 The storage is a sub-module dmem_array: single-port synchronous write, asynchronous read, DEPTH_WORDS x 32.

Verification
REQ-034 WAIT_CYCLES=1: store 32'hDEADBEEF to 0x10 at edge N -> wr_done high during cycle N+2; load 0x10 -> mrd_d=32'hDEADBEEF with mrd_valid.
REQ-035 WAIT_CYCLES=0: loads 0x0, 0x4, 0x8 issued back-to-back -> mrd_valid every second cycle; mem_ready toggles 1,0,1,0.
REQ-036 DEPTH_WORDS=256: load 0x400 -> mrd_d=0, mrd_valid=1, err=1; store 0x400 then load 0x0 -> word 0 unchanged.
REQ-037 mwr_d=1 and mrd_en=1 together, address 0x20, data 32'h1234 -> wr_done only, no mrd_valid; load 0x20 returns 32'h1234.
REQ-038 WAIT_CYCLES=3: reset driven low in the second BUSY cycle of a store -> no wr_done, mem_ready=1 after release, word unchanged.
REQ-039 Load 0x12: with DMEM_ALIGN_CHECK_EN defined -> err=1, mrd_d=0; without it -> returns the contents of word 0x10, err=0.
